// File: rtl/ex_stage_md_pkg.sv
// Shared encodings for the M-extension execute stage.
// Optional macro EX_FAST_MUL_EN is consumed by ex_stage_md.
package ex_stage_md_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // forward select: bit0 = MEM, bit1 = WB; MEM wins when both set
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam int FWD_MEM_BIT = 0;
  localparam int FWD_WB_BIT  = 1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic int cnt_w(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/alu.sv
// Base integer ALU. Ports: op (ALU_OP_W), a, b (XLEN) in; y (XLEN) out.
// Pure combinational; shifts use the low log2(XLEN) bits of b.
module alu
  import ex_stage_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  logic          lt;
  logic          ltu;

  assign sh  = b[SW-1:0];
  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $signed(a) >>> sh;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide with IDLE/BUSY/DONE FSM.
// In: clk, rst_n, start, flush, hold, op, a, b. Out: busy, done, result.
module ex_muldiv
  import ex_stage_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            hold,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = cnt_w(XLEN);

  md_state_e       state, state_n;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] m, hi, lo;
  logic [2:0]      op_q;
  logic            neg;

  logic            is_div, sa, sb, div0, ovf;
  logic [XLEN-1:0] ma, mb;

  assign is_div = op[2];
  assign sa = a[XLEN-1] & (op == MD_MULH || op == MD_MULHSU ||
                           op == MD_DIV  || op == MD_REM);
  assign sb = b[XLEN-1] & (op == MD_MULH || op == MD_DIV ||
                           op == MD_REM);
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign div0 = is_div & (b == '0);
  assign ovf  = is_div & sa & sb & (b == '1) &
                (a == {1'b1, {(XLEN-1){1'b0}}});

  always_comb begin
    state_n = state;
    unique case (state)
      MD_IDLE: if (start) state_n = (div0 | ovf) ? MD_DONE : MD_BUSY;
      MD_BUSY: if (cnt == '0) state_n = MD_DONE;
      MD_DONE: if (!hold) state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
    if (flush) state_n = MD_IDLE;
  end

  assign busy = (state == MD_IDLE && start) || state == MD_BUSY;
  assign done = state == MD_DONE;

  // mul: {hi,lo} shifts right with conditional add of m into hi
  // div: restoring step, remainder in hi, quotient shifts into lo
  logic [XLEN:0]   sum, sh;
  logic            ge;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    sum = {1'b0, hi} + {1'b0, {XLEN{lo[0]}} & m};
    sh  = {hi, lo[XLEN-1]};
    ge  = sh >= {1'b0, m};
    if (op_q[2]) begin
      hi_n = ge ? sh[XLEN-1:0] - m : sh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == MD_IDLE && start) begin
        op_q <= op;
        cnt  <= CW'(XLEN-1);
        m    <= is_div ? mb : ma;
        hi   <= '0;
        lo   <= is_div ? ma : mb;
        // remainder takes the dividend sign
        neg  <= (op[2] & op[1]) ? sa : (sa ^ sb);
        // special cases preload the final quotient/remainder
        if (div0) begin
          neg <= 1'b0;
          hi  <= a;
          lo  <= '1;
        end else if (ovf) begin
          neg <= 1'b0;
          lo  <= a;
        end
      end else if (state == MD_BUSY) begin
        cnt <= cnt - 1'b1;
        hi  <= hi_n;
        lo  <= lo_n;
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q, r;

  assign prod = neg ? -{hi, lo} : {hi, lo};
  assign q    = neg ? -lo : lo;
  assign r    = neg ? -hi : hi;

  always_comb begin
    result = r;
    unique case (op_q)
      MD_MUL:                      result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result = q;
      default:                     result = r;
    endcase
  end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding, operand muxes, ALU, LSU addr, M-ext, ex2mem reg.
// Ports: id2ex_* bundle, wb_reg_wdata, mem_stall in; ex_stall, lsu_*, ex2mem_* out.
// Macro EX_FAST_MUL_EN: single-cycle multiplier for MUL* ops.
module ex_stage_md
  import ex_stage_md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id2ex_valid,
  input  logic [XLEN-1:0]     id2ex_pc,
  input  logic [XLEN-1:0]     id2ex_op1_data,
  input  logic [XLEN-1:0]     id2ex_op2_data,
  input  logic [XLEN-1:0]     id2ex_imm_value,
  input  logic                id2ex_reg_wen,
  input  logic [RF_AW-1:0]    id2ex_reg_waddr,
  input  logic [ALU_OP_W-1:0] id2ex_alu_op,
  input  logic                id2ex_md_instr,
  input  logic [2:0]          id2ex_md_op,
  input  logic                id2ex_sel_imm,
  input  logic                id2ex_op1_sel_pc,
  input  logic                id2ex_op1_sel_zero,
  input  logic                id2ex_op2_sel_4,
  input  logic [1:0]          id2ex_op1_fwd,
  input  logic [1:0]          id2ex_op2_fwd,
  input  logic                id2ex_mem_rd,
  input  logic                id2ex_ill_instr,
  input  logic                id2ex_flush,
  input  logic [XLEN-1:0]     wb_reg_wdata,
  input  logic                mem_stall,
  output logic                ex_stall,
  output logic [XLEN-1:0]     lsu_addr,
  output logic [XLEN-1:0]     lsu_wdata,
  output logic                ex2mem_valid,
  output logic                ex2mem_reg_wen,
  output logic                ex2mem_mem_rd,
  output logic                ex2mem_ill_instr,
  output logic [RF_AW-1:0]    ex2mem_reg_waddr,
  output logic [XLEN-1:0]     ex2mem_alu_out
);

  logic [XLEN-1:0] op1_fwd, op2_fwd, op1, op2;
  logic [XLEN-1:0] alu_res, ex_res, md_res;
  logic            md_iter, md_start, md_busy, md_done, take;

  assign op1_fwd = id2ex_op1_fwd[FWD_MEM_BIT] ? ex2mem_alu_out :
                   id2ex_op1_fwd[FWD_WB_BIT]  ? wb_reg_wdata   :
                                                id2ex_op1_data;
  assign op2_fwd = id2ex_op2_fwd[FWD_MEM_BIT] ? ex2mem_alu_out :
                   id2ex_op2_fwd[FWD_WB_BIT]  ? wb_reg_wdata   :
                                                id2ex_op2_data;

  assign op1 = id2ex_op1_sel_pc   ? id2ex_pc :
               id2ex_op1_sel_zero ? '0       : op1_fwd;
  assign op2 = id2ex_sel_imm      ? id2ex_imm_value :
               id2ex_op2_sel_4    ? XLEN'(4)        : op2_fwd;

  assign lsu_addr  = op1_fwd + id2ex_imm_value;
  assign lsu_wdata = op2_fwd;

  alu #(.XLEN(XLEN)) u_alu (
    .op (id2ex_alu_op),
    .a  (op1),
    .b  (op2),
    .y  (alu_res)
  );

`ifdef EX_FAST_MUL_EN
  logic              fsa, fsb;
  logic [2*XLEN-1:0] fm_a, fm_b, fm_p;

  assign fsa  = id2ex_md_op == MD_MULH || id2ex_md_op == MD_MULHSU;
  assign fsb  = id2ex_md_op == MD_MULH;
  assign fm_a = {{XLEN{fsa & op1_fwd[XLEN-1]}}, op1_fwd};
  assign fm_b = {{XLEN{fsb & op2_fwd[XLEN-1]}}, op2_fwd};
  assign fm_p = fm_a * fm_b;

  assign md_iter = id2ex_md_instr & id2ex_md_op[2];
  assign ex_res  = !id2ex_md_instr           ? alu_res            :
                   (id2ex_md_op == MD_MUL)   ? fm_p[XLEN-1:0]     :
                                               fm_p[2*XLEN-1:XLEN];
`else
  assign md_iter = id2ex_md_instr;
  assign ex_res  = alu_res;
`endif

  assign md_start = id2ex_valid & md_iter & ~id2ex_flush;

  ex_muldiv #(.XLEN(XLEN)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .flush  (id2ex_flush),
    .hold   (mem_stall),
    .op     (id2ex_md_op),
    .a      (op1_fwd),
    .b      (op2_fwd),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  assign ex_stall = md_busy & ~id2ex_flush;
  assign take     = id2ex_valid & ~id2ex_flush & ~ex_stall;

  // bubbles leave data fields alone so MEM forwarding stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex2mem_valid     <= 1'b0;
      ex2mem_reg_wen   <= 1'b0;
      ex2mem_mem_rd    <= 1'b0;
      ex2mem_ill_instr <= 1'b0;
      ex2mem_reg_waddr <= '0;
      ex2mem_alu_out   <= '0;
    end else if (!mem_stall) begin
      ex2mem_valid     <= take;
      ex2mem_reg_wen   <= take & id2ex_reg_wen;
      ex2mem_mem_rd    <= take & id2ex_mem_rd;
      ex2mem_ill_instr <= take & id2ex_ill_instr;
      if (take) begin
        ex2mem_reg_waddr <= id2ex_reg_waddr;
        ex2mem_alu_out   <= md_done ? md_res : ex_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: vector table, hand sequences,
// randomized ALU and M-extension ops against a behavioural model.
module tb_ex_stage_md;
  import ex_stage_md_pkg::*;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;
`ifdef EX_FAST_MUL_EN
  localparam int MS = 0;
`else
  localparam int MS = XLEN + 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id2ex_valid;
  logic [XLEN-1:0]     id2ex_pc, id2ex_op1_data, id2ex_op2_data;
  logic [XLEN-1:0]     id2ex_imm_value;
  logic                id2ex_reg_wen;
  logic [RF_AW-1:0]    id2ex_reg_waddr;
  logic [ALU_OP_W-1:0] id2ex_alu_op;
  logic                id2ex_md_instr;
  logic [2:0]          id2ex_md_op;
  logic                id2ex_sel_imm, id2ex_op1_sel_pc;
  logic                id2ex_op1_sel_zero, id2ex_op2_sel_4;
  logic [1:0]          id2ex_op1_fwd, id2ex_op2_fwd;
  logic                id2ex_mem_rd, id2ex_ill_instr, id2ex_flush;
  logic [XLEN-1:0]     wb_reg_wdata;
  logic                mem_stall;
  logic                ex_stall;
  logic [XLEN-1:0]     lsu_addr, lsu_wdata;
  logic                ex2mem_valid, ex2mem_reg_wen;
  logic                ex2mem_mem_rd, ex2mem_ill_instr;
  logic [RF_AW-1:0]    ex2mem_reg_waddr;
  logic [XLEN-1:0]     ex2mem_alu_out;

  ex_stage_md #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id2ex_valid        (id2ex_valid),
    .id2ex_pc           (id2ex_pc),
    .id2ex_op1_data     (id2ex_op1_data),
    .id2ex_op2_data     (id2ex_op2_data),
    .id2ex_imm_value    (id2ex_imm_value),
    .id2ex_reg_wen      (id2ex_reg_wen),
    .id2ex_reg_waddr    (id2ex_reg_waddr),
    .id2ex_alu_op       (id2ex_alu_op),
    .id2ex_md_instr     (id2ex_md_instr),
    .id2ex_md_op        (id2ex_md_op),
    .id2ex_sel_imm      (id2ex_sel_imm),
    .id2ex_op1_sel_pc   (id2ex_op1_sel_pc),
    .id2ex_op1_sel_zero (id2ex_op1_sel_zero),
    .id2ex_op2_sel_4    (id2ex_op2_sel_4),
    .id2ex_op1_fwd      (id2ex_op1_fwd),
    .id2ex_op2_fwd      (id2ex_op2_fwd),
    .id2ex_mem_rd       (id2ex_mem_rd),
    .id2ex_ill_instr    (id2ex_ill_instr),
    .id2ex_flush        (id2ex_flush),
    .wb_reg_wdata       (wb_reg_wdata),
    .mem_stall          (mem_stall),
    .ex_stall           (ex_stall),
    .lsu_addr           (lsu_addr),
    .lsu_wdata          (lsu_wdata),
    .ex2mem_valid       (ex2mem_valid),
    .ex2mem_reg_wen     (ex2mem_reg_wen),
    .ex2mem_mem_rd      (ex2mem_mem_rd),
    .ex2mem_ill_instr   (ex2mem_ill_instr),
    .ex2mem_reg_waddr   (ex2mem_reg_waddr),
    .ex2mem_alu_out     (ex2mem_alu_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id2ex_valid = 0; id2ex_pc = '0;
    id2ex_op1_data = '0; id2ex_op2_data = '0; id2ex_imm_value = '0;
    id2ex_reg_wen = 0; id2ex_reg_waddr = '0; id2ex_alu_op = ALU_ADD;
    id2ex_md_instr = 0; id2ex_md_op = '0;
    id2ex_sel_imm = 0; id2ex_op1_sel_pc = 0;
    id2ex_op1_sel_zero = 0; id2ex_op2_sel_4 = 0;
    id2ex_op1_fwd = FWD_REG; id2ex_op2_fwd = FWD_REG;
    id2ex_mem_rd = 0; id2ex_ill_instr = 0; id2ex_flush = 0;
    wb_reg_wdata = '0; mem_stall = 0;
  endtask

  // behavioural M-extension reference using 64-bit host arithmetic
  function automatic logic [31:0] md_ref(input logic [2:0] op,
                                         input logic [31:0] a, b);
    longint    sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    logic        ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (op)
      MD_MUL:    begin p = ua * ub; r = p[31:0]; end
      MD_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
      MD_MULHU:  begin p = ua * ub; r = p[63:32]; end
      MD_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a :
                     32'($signed(a) / $signed(b));
      MD_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM:    r = (b == 0) ? a : ovf ? 32'd0 :
                     32'($signed(a) % $signed(b));
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int st_ref(input logic [2:0] op,
                                input logic [31:0] a, b);
    if (!op[2]) return MS;
    if (b == 0) return 1;
    if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a, b);
    int s;
    s = int'(b % 32);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << s;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> s;
      ALU_SRA:  return 32'($signed(a) >>> s);
      ALU_OR:   return a | b;
      default:  return a & b;
    endcase
  endfunction

  task automatic set_md(input logic [2:0] op, input logic [31:0] a, b);
    id2ex_valid = 1; id2ex_md_instr = 1; id2ex_md_op = op;
    id2ex_op1_data = a; id2ex_op2_data = b;
    id2ex_reg_wen = 1; id2ex_reg_waddr = 5'd7;
    id2ex_op1_fwd = FWD_REG; id2ex_op2_fwd = FWD_REG;
  endtask

  task automatic issue_md(input string nm, input logic [2:0] op,
                          input logic [31:0] a, b, exp, input int est);
    int st, bad;
    st = 0; bad = 0;
    set_md(op, a, b);
    #1;
    while (ex_stall && st < 200) begin
      tick();
      st++;
      if (ex2mem_valid || ex2mem_reg_wen) bad++;
    end
    check({nm, "_stalls"}, 64'(st), 64'(est));
    check({nm, "_bubbles"}, 64'(bad), 64'd0);
    tick();
    check({nm, "_valid"}, {63'd0, ex2mem_valid}, 64'd1);
    check({nm, "_result"}, {32'd0, ex2mem_alu_out}, {32'd0, exp});
    id2ex_valid = 0; id2ex_md_instr = 0;
  endtask

  task automatic issue_alu(input string nm, input logic [3:0] op,
                           input logic [31:0] a, b, exp);
    id2ex_valid = 1; id2ex_md_instr = 0; id2ex_alu_op = op;
    id2ex_op1_data = a; id2ex_op2_data = b; id2ex_reg_wen = 1;
    #1;
    check({nm, "_stall"}, {63'd0, ex_stall}, 64'd0);
    tick();
    check({nm, "_res"}, {32'd0, ex2mem_alu_out}, {32'd0, exp});
    id2ex_valid = 0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          st;
  } md_vec_t;

  md_vec_t tab[11];
  logic [3:0] aops[10];

  initial begin
    tab[0]  = '{MD_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
    tab[1]  = '{MD_REM,    32'd100,       32'hFFFF_FFF9, 32'd2,         33};
    tab[2]  = '{MD_DIVU,   32'd55,        32'd0,         32'hFFFF_FFFF, 1};
    tab[3]  = '{MD_REMU,   32'h1234,      32'd0,         32'h1234,      1};
    tab[4]  = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tab[5]  = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    tab[6]  = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MS};
    tab[7]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MS};
    tab[8]  = '{MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MS};
    tab[9]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MS};
    tab[10] = '{MD_DIVU,   32'd9,         32'd2,         32'd4,         33};
    aops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
             ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

    clear_in();
    rst_n = 0;
    #1;
    check("rst_outs", {26'd0, ex2mem_valid, ex2mem_reg_wen, ex2mem_mem_rd,
          ex2mem_ill_instr, ex2mem_reg_waddr, ex2mem_alu_out}, 64'd0);
    check("rst_stall", {63'd0, ex_stall}, 64'd0);
    tick(); tick();
    rst_n = 1;
    tick();

    // forwarding and operand selects
    issue_alu("add_base", ALU_ADD, 32'd2, 32'd3, 32'd5);
    id2ex_op1_fwd = FWD_MEM; id2ex_sel_imm = 1; id2ex_imm_value = 32'd7;
    id2ex_mem_rd = 1; id2ex_reg_waddr = 5'd9;
    id2ex_valid = 1; id2ex_alu_op = ALU_ADD; id2ex_op1_data = 32'd999;
    #1;
    check("fwd_lsu_addr", {32'd0, lsu_addr}, 64'd12);
    check("fwd_stall", {63'd0, ex_stall}, 64'd0);
    tick();
    check("fwd_mem_add", {32'd0, ex2mem_alu_out}, 64'd12);
    check("fwd_ctrl", {57'd0, ex2mem_mem_rd, ex2mem_valid, ex2mem_reg_waddr},
          {57'd0, 1'b1, 1'b1, 5'd9});
    clear_in();
    wb_reg_wdata = 32'd100; id2ex_op1_fwd = FWD_WB;
    issue_alu("fwd_wb_sub", ALU_SUB, 32'd1, 32'd30, 32'd70);
    id2ex_op1_fwd = 2'b11; id2ex_op2_fwd = FWD_WB;
    #1;
    check("fwd_lsu_wdata", {32'd0, lsu_wdata}, 64'd100);
    issue_alu("fwd_prio", ALU_ADD, 32'd1, 32'd1, 32'd170);
    clear_in();

    for (int i = 0; i < 20; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = aops[$urandom_range(0, 9)];
      a = $urandom; b = $urandom;
      issue_alu($sformatf("rnd_alu%0d", i), op, a, b, alu_ref(op, a, b));
    end

    for (int i = 0; i < 11; i++)
      issue_md($sformatf("tab%0d", i), tab[i].op, tab[i].a, tab[i].b,
               tab[i].exp, tab[i].st);

    // mem_stall held while the result sits in DONE
    begin
      int st;
      st = 0;
      set_md(MD_DIV, 32'd100, 32'd7);
      #1;
      while (ex_stall && st < 200) begin tick(); st++; end
      check("ms_stalls", 64'(st), 64'd33);
      mem_stall = 1;
      for (int k = 0; k < 3; k++) begin
        tick();
        check($sformatf("ms_hold%0d", k), {62'd0, ex_stall, ex2mem_valid},
              64'd0);
      end
      mem_stall = 0;
      tick();
      check("ms_write", {31'd0, ex2mem_valid, ex2mem_alu_out},
            {31'd0, 1'b1, 32'd14});
      clear_in();
      tick();
      check("ms_once", {62'd0, ex_stall, ex2mem_valid}, 64'd0);
    end

    // flush in the fifth BUSY cycle
    begin
      int hi;
      hi = 0;
      set_md(MD_DIV, 32'd100, 32'd7);
      for (int k = 0; k < 6; k++) tick();
      id2ex_flush = 1;
      #1;
      check("fl_stall", {63'd0, ex_stall}, 64'd0);
      tick();
      check("fl_valid", {63'd0, ex2mem_valid}, 64'd0);
      clear_in();
      #1;
      for (int k = 0; k < 40; k++) begin
        if (ex_stall || ex2mem_valid) hi++;
        tick();
      end
      check("fl_idle", 64'(hi), 64'd0);
      issue_md("fl_next", MD_DIVU, 32'd9, 32'd2, 32'd4, 33);
    end

    // asynchronous reset in the tenth BUSY cycle
    set_md(MD_DIV, 32'd100, 32'd7);
    for (int k = 0; k < 11; k++) tick();
    #2;
    rst_n = 0;
    clear_in();
    #1;
    check("ar_outs", {31'd0, ex2mem_valid, ex2mem_alu_out}, 64'd0);
    check("ar_stall", {63'd0, ex_stall}, 64'd0);
    tick();
    rst_n = 1;
    tick();
    issue_md("ar_next", MD_DIVU, 32'd9, 32'd2, 32'd4, 33);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      issue_md($sformatf("rnd_md%0d", i), op, a, b, md_ref(op, a, b),
               st_ref(op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
